fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the IF stage. Owns the PC register and drives pc_mux_sel into the next-PC mux.
//  Arbitrates redirect requests (branch / jr-jalr / j-jal) against sequential fetch.
//  Honours hazard-unit stalls; a redirect raised during a stall is held, not lost.
//  Tells the IF/ID register when the fetched word is valid and when to squash it.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (word aligned)
//  CNT_W      32             width of statistics counters (FETCH_STATS_EN only)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous reset, active low
//  stall         in   1      hazard unit: hold PC and IF/ID this cycle
//  br_taken      in   1      beq/bne/bgez resolved taken; target presented on b_pc
//  jr_req        in   1      jr/jalr redirect; target on r_pc
//  j_req         in   1      j/jal redirect; target on j_pc
//  npc           in   32     next PC returned from the IF-stage mux (selected by pc_mux_sel)
//  pc            out  32     current fetch PC
//  pc_mux_sel    out  3      `PC_SEL_J=0, `PC_SEL_R=1, `PC_SEL_PC4=2, `PC_SEL_B=4
//  if_valid      out  1      instruction at pc is a real fetch (IF/ID load-valid)
//  ifid_flush    out  1      squash the word currently in IF/ID (wrong-path)
//  redirect_busy out  1      a redirect is latched and waiting for stall to drop
//  fetch_cnt     out  CNT_W  valid fetches retired into IF/ID
//  redir_cnt     out  CNT_W  redirects applied
// BEHAVIOUR
//  - Reset (rst_n=0, async): pc=RESET_PC, state=BOOT, pend_pc=0, if_valid=0, ifid_flush=0,
//    redirect_busy=0, counters=0, pc_mux_sel=`PC_SEL_PC4.
//  - Select priority, combinational: br_taken > jr_req > j_req > sequential (PC4).
//    Simultaneous requests: highest priority wins; lower ones are dropped (issuer re-raises).
//  - States:
//    BOOT : 1 cycle after reset release; if_valid=0, pc holds; -> RUN.
//    RUN  : !stall -> pc<=npc; if a request was active, ifid_flush=1 same cycle, redir_cnt++.
//           stall & request -> pend_pc<=npc, pc holds -> PEND.
//           stall & no request -> pc holds, stay RUN.
//    PEND : redirect_busy=1, pc_mux_sel=`PC_SEL_PC4 (mux output ignored), new requests ignored.
//           stall -> hold. !stall -> pc<=pend_pc, ifid_flush=1, redir_cnt++ -> RUN.
//  - if_valid=1 in RUN and PEND except the cycle ifid_flush=1 (wrong-path slot); 0 in BOOT.
//  - fetch_cnt++ on every edge with if_valid & !stall & !ifid_flush.
//  - Latency: redirect request -> new pc visible 1 clock later (0 extra cycles if unstalled).
//  - pc[1:0] forced to 00 on every load; 32-bit adder wrap 32'hFFFF_FFFC -> 0 is legal, no flag.
//  - Counters saturate at all-ones (no wrap).
//  - rst_n asserted mid-PEND: pending redirect discarded, fetch restarts at RESET_PC.
// CONFIGURATION
//  - FETCH_STATS_EN defined: fetch_cnt/redir_cnt implemented as above.
//  - FETCH_STATS_EN undefined: ports still present, tied to 0; no counter flops.
// STRUCTURE
//  - define.v gains: `PC_SEL_J/`PC_SEL_R/`PC_SEL_PC4/`PC_SEL_B codes, state encodings
//    `FC_BOOT=2'd0, `FC_RUN=2'd1, `FC_PEND=2'd2.
//  - One sub-module: fetch_redirect_latch (pend_pc register + PEND flag, load/clear controls);
//    the FSM, priority select and counters stay in fetch_ctrl.
// TESTING
//  1 Reset release, no requests, npc=pc+4 -> BOOT 1 cycle (if_valid=0), then pc=0,4,8,... one per clk.
//  2 pc=0x40, br_taken=1, b_pc=0x100, no stall -> pc_mux_sel=4, next pc=0x100, ifid_flush=1 for 1 cycle.
//  3 br_taken, jr_req, j_req all high, r_pc=0x200, j_pc=0x300, b_pc=0x100 -> sel=4, pc=0x100.
//  4 pc=0x80, stall=1 for 3 cycles, j_req=1 on 1st stall cycle with j_pc=0x400 ->
//    redirect_busy=1, pc holds 0x80; stall drops -> pc=0x400, ifid_flush=1, redirect_busy=0.
//  5 rst_n low while in PEND (pend_pc=0x400) -> pc=RESET_PC immediately, redirect_busy=0, no jump to 0x400.
//  6 FETCH_STATS_EN: 10 unstalled fetches + 2 redirects -> fetch_cnt=8, redir_cnt=2; macro off -> both 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the IF-stage fetch sequencer: next-PC mux selects,
// FSM state codes and the word-alignment helper applied to every PC load.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_BOOT = 2'd0,
        FC_RUN  = 2'd1,
        FC_PEND = 2'd2
    } fc_state_t;

    localparam logic [2:0] PC_SEL_J   = 3'd0;
    localparam logic [2:0] PC_SEL_R   = 3'd1;
    localparam logic [2:0] PC_SEL_PC4 = 3'd2;
    localparam logic [2:0] PC_SEL_B   = 3'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_latch.sv
// Holds a redirect target captured while the pipe is stalled, plus the flag
// marking it as pending until the stall drops and the target is applied.
module fetch_redirect_latch
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    output logic [31:0] pend_pc,
    output logic        pend
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pc <= 32'h0000_0000;
            pend    <= 1'b0;
        end else if (load) begin
            pend_pc <= word_align(load_pc);
            pend    <= 1'b1;
        end else if (clear) begin
            pend    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, arbitrates redirects against sequential
// fetch and parks redirects raised under stall. Statistics counters exist
// only when FETCH_STATS_EN is defined; otherwise the count ports read 0.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jr_req,
    input  logic             j_req,
    input  logic [31:0]      npc,
    output logic [31:0]      pc,
    output logic [2:0]       pc_mux_sel,
    output logic             if_valid,
    output logic             ifid_flush,
    output logic             redirect_busy,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    fc_state_t   state;
    logic        req;
    logic        latch_load;
    logic        latch_clear;
    logic [31:0] pend_pc;
    logic        pend;

    assign req = br_taken | jr_req | j_req;

    // Requests only steer the mux in RUN; while a redirect is parked the mux output is ignored.
    always_comb begin
        pc_mux_sel = PC_SEL_PC4;
        if (state == FC_RUN) begin
            if (br_taken)    pc_mux_sel = PC_SEL_B;
            else if (jr_req) pc_mux_sel = PC_SEL_R;
            else if (j_req)  pc_mux_sel = PC_SEL_J;
        end
    end

    // The word sitting at pc is wrong-path in any cycle a redirect is applied.
    assign ifid_flush    = !stall && (((state == FC_RUN) && req) || (state == FC_PEND));
    assign if_valid      = (state != FC_BOOT) && !ifid_flush;
    assign latch_load    = (state == FC_RUN) && stall && req;
    assign latch_clear   = (state == FC_PEND) && !stall;
    assign redirect_busy = pend;

    fetch_redirect_latch u_redirect_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (latch_load),
        .clear   (latch_clear),
        .load_pc (npc),
        .pend_pc (pend_pc),
        .pend    (pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FC_BOOT;
            pc    <= RESET_PC;
        end else begin
            case (state)
                FC_BOOT: state <= FC_RUN;
                FC_RUN: begin
                    if (!stall)   pc    <= word_align(npc);
                    else if (req) state <= FC_PEND;
                end
                FC_PEND: begin
                    if (!stall) begin
                        pc    <= pend_pc;
                        state <= FC_RUN;
                    end
                end
                default: state <= FC_BOOT;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (if_valid && !stall) fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (ifid_flush)         redir_cnt_q <= sat_inc(redir_cnt_q);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign redir_cnt = redir_cnt_q;
`else
    assign fetch_cnt = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the external next-PC mux and checks
// PC sequencing, redirect priority, stall parking, async reset and counters.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic        jr_req;
    logic        j_req;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [2:0]  pc_mux_sel;
    logic        if_valid;
    logic        ifid_flush;
    logic        redirect_busy;
    logic [31:0] fetch_cnt;
    logic [31:0] redir_cnt;

    logic [31:0] b_pc;
    logic [31:0] r_pc;
    logic [31:0] j_pc;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .br_taken      (br_taken),
        .jr_req        (jr_req),
        .j_req         (j_req),
        .npc           (npc),
        .pc            (pc),
        .pc_mux_sel    (pc_mux_sel),
        .if_valid      (if_valid),
        .ifid_flush    (ifid_flush),
        .redirect_busy (redirect_busy),
        .fetch_cnt     (fetch_cnt),
        .redir_cnt     (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IF-stage next-PC mux as it sits outside the sequencer
    always_comb begin
        case (pc_mux_sel)
            3'd0:    npc = j_pc;
            3'd1:    npc = r_pc;
            3'd4:    npc = b_pc;
            default: npc = pc + 32'd4;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        br_taken = 1'b0;
        jr_req   = 1'b0;
        j_req    = 1'b0;
    endtask

    logic [31:0] exp_pc;

    initial begin
        rst_n = 1'b0; stall = 1'b0; clr_req();
        b_pc = 32'h0; r_pc = 32'h0; j_pc = 32'h0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_flush", {31'd0, ifid_flush}, 32'd0);
        chk("rst_busy", {31'd0, redirect_busy}, 32'd0);
        chk("rst_sel", {29'd0, pc_mux_sel}, 32'd2);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_redir_cnt", redir_cnt, 32'd0);

        // Test 1: BOOT holds one cycle, then sequential fetch
        rst_n = 1'b1; #1;
        chk("boot_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("boot_pc_hold", pc, 32'h0);
        chk("run_if_valid", {31'd0, if_valid}, 32'd1);
        chk("run_sel_pc4", {29'd0, pc_mux_sel}, 32'd2);
        exp_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            chk("seq_pc", pc, exp_pc);
        end
        chk("seq_pc_0x40", pc, 32'h40);

        // Test 2: taken branch, unstalled
        br_taken = 1'b1; b_pc = 32'h100; #1;
        chk("br_sel", {29'd0, pc_mux_sel}, 32'd4);
        chk("br_flush", {31'd0, ifid_flush}, 32'd1);
        chk("br_if_valid", {31'd0, if_valid}, 32'd0);
        tick(); clr_req(); #1;
        chk("br_pc", pc, 32'h100);
        chk("br_flush_drop", {31'd0, ifid_flush}, 32'd0);
        chk("br_if_valid_back", {31'd0, if_valid}, 32'd1);
        tick();
        chk("br_seq", pc, 32'h104);

        // Test 3: all requests at once, branch wins
        br_taken = 1'b1; jr_req = 1'b1; j_req = 1'b1;
        b_pc = 32'h100; r_pc = 32'h200; j_pc = 32'h300; #1;
        chk("prio_all_sel", {29'd0, pc_mux_sel}, 32'd4);
        tick(); clr_req();
        chk("prio_all_pc", pc, 32'h100);

        // jr beats j; j alone; misaligned target is word-aligned on load
        jr_req = 1'b1; j_req = 1'b1; r_pc = 32'h200; j_pc = 32'h300; #1;
        chk("prio_jr_sel", {29'd0, pc_mux_sel}, 32'd1);
        tick(); clr_req();
        chk("prio_jr_pc", pc, 32'h200);
        j_req = 1'b1; j_pc = 32'h123; #1;
        chk("j_sel", {29'd0, pc_mux_sel}, 32'd0);
        tick(); clr_req();
        chk("align_pc", pc, 32'h120);
        j_req = 1'b1; j_pc = 32'h80;
        tick(); clr_req();
        chk("j_pc_0x80", pc, 32'h80);

        // Test 4: redirect raised under stall is parked, then applied
        stall = 1'b1; j_req = 1'b1; j_pc = 32'h400; #1;
        chk("stall_req_flush", {31'd0, ifid_flush}, 32'd0);
        tick(); clr_req();
        chk("pend_busy", {31'd0, redirect_busy}, 32'd1);
        chk("pend_pc_hold", pc, 32'h80);
        br_taken = 1'b1; b_pc = 32'h500; #1;
        chk("pend_sel_pc4", {29'd0, pc_mux_sel}, 32'd2);
        chk("pend_if_valid", {31'd0, if_valid}, 32'd1);
        tick();
        tick(); clr_req();
        chk("pend_pc_hold3", pc, 32'h80);
        chk("pend_busy3", {31'd0, redirect_busy}, 32'd1);
        stall = 1'b0; #1;
        chk("pend_release_flush", {31'd0, ifid_flush}, 32'd1);
        tick();
        chk("pend_applied_pc", pc, 32'h400);
        chk("pend_busy_clear", {31'd0, redirect_busy}, 32'd0);
        chk("pend_flush_drop", {31'd0, ifid_flush}, 32'd0);
        tick();
        chk("pend_then_seq", pc, 32'h404);

        // Test 5: async reset while a redirect is parked
        stall = 1'b1; j_req = 1'b1; j_pc = 32'h400;
        tick(); clr_req();
        chk("pend2_busy", {31'd0, redirect_busy}, 32'd1);
        #2; rst_n = 1'b0; #1;
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_busy", {31'd0, redirect_busy}, 32'd0);
        chk("rst_mid_if_valid", {31'd0, if_valid}, 32'd0);
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_boot_pc", pc, 32'h0);

        // Test 6: 10 unstalled edges, redirects on the 3rd and 7th
        exp_pc = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                j_req = 1'b1; j_pc = 32'h1000;
            end else if (i == 7) begin
                j_req = 1'b1; j_pc = 32'h2000;
            end
            tick(); clr_req();
            if (i == 3)      exp_pc = 32'h1000;
            else if (i == 7) exp_pc = 32'h2000;
            else             exp_pc = exp_pc + 32'd4;
            chk("cnt_seq_pc", pc, exp_pc);
        end
        chk("cnt_final_pc", pc, 32'h200C);
`ifdef FETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, 32'd8);
        chk("redir_cnt", redir_cnt, 32'd2);
`else
        chk("fetch_cnt_off", fetch_cnt, 32'd0);
        chk("redir_cnt_off", redir_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
